// File: rtl/t_route_stage.sv
// t_route_stage: fat-tree switch input stage; decodes each port's direction, ages packets
// and keeps saturating traffic counters.
module t_route_stage #(
    parameter int P_W      = 49,
    parameter int A_W      = 8,
    parameter int AGE_W    = 4,
    parameter int level    = 1,
    parameter int pos      = 0,
    parameter int N_LEVELS = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [P_W-1:0] l_bus_i,
    input  logic [P_W-1:0] r_bus_i,
    input  logic [P_W-1:0] u_bus_i,
    output logic [P_W-1:0] l_pkt_o,
    output logic [P_W-1:0] r_pkt_o,
    output logic [P_W-1:0] u_pkt_o,
    output logic [1:0]     d_l,
    output logic [1:0]     d_r,
    output logic [1:0]     d_u,
    input  logic           cnt_clr,
    input  logic [1:0]     cnt_sel,
    output logic [15:0]    cnt_o
);
    localparam int AH = P_W - 2;
    localparam int AL = P_W - 1 - A_W;
    localparam int GH = AL - 1;
    localparam int GL = AL - AGE_W;
    localparam int HW = A_W - level - 1;
    localparam logic [A_W-1:0] POS_T = A_W'(pos % (1 << HW));

    // 00 VOID, 01 LEFT, 10 RIGHT, 11 UP; the root owns every address
    function automatic logic [1:0] dir(input logic [P_W-1:0] p);
        logic [A_W-1:0] a;
        a = p[AH:AL];
        if (!p[P_W-1]) return 2'b00;
        if (level != N_LEVELS - 1 && (a >> (level + 1)) != POS_T) return 2'b11;
        return a[level] ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [P_W-1:0] aged(input logic [P_W-1:0] p);
        logic [P_W-1:0] q;
        q = p;
        if (q[GH:GL] != '1) q[GH:GL] = q[GH:GL] + 1'b1;
        return p[P_W-1] ? q : '0;
    endfunction

    function automatic logic [15:0] inc(input logic [15:0] c, input logic v);
        return c + 16'(v && c != 16'hFFFF);
    endfunction

    logic [1:0]  nl, nr, nu, n_up;
    logic [15:0] c_l, c_r, c_u, c_q;
    logic [16:0] q_sum;

    always_comb begin
        nl = dir(l_bus_i);
        nr = dir(r_bus_i);
        nu = dir(u_bus_i);
        n_up = 2'(nl == 2'b11) + 2'(nr == 2'b11) + 2'(nu == 2'b11);
        q_sum = {1'b0, c_q} + 17'(n_up);
        cnt_o = cnt_sel == 2'd0 ? c_l : cnt_sel == 2'd1 ? c_r : cnt_sel == 2'd2 ? c_u : c_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_pkt_o <= '0;
            r_pkt_o <= '0;
            u_pkt_o <= '0;
            d_l <= 2'b00;
            d_r <= 2'b00;
            d_u <= 2'b00;
            c_l <= '0;
            c_r <= '0;
            c_u <= '0;
            c_q <= '0;
        end else begin
            l_pkt_o <= aged(l_bus_i);
            r_pkt_o <= aged(r_bus_i);
            u_pkt_o <= aged(u_bus_i);
            d_l <= nl;
            d_r <= nr;
            d_u <= nu;
            c_l <= cnt_clr ? '0 : inc(c_l, l_bus_i[P_W-1]);
            c_r <= cnt_clr ? '0 : inc(c_r, r_bus_i[P_W-1]);
            c_u <= cnt_clr ? '0 : inc(c_u, u_bus_i[P_W-1]);
            c_q <= cnt_clr ? '0 : q_sum[16] ? 16'hFFFF : q_sum[15:0];
        end
    end
endmodule

// File: tb/tb_t_route_stage.sv
// tb_t_route_stage: drives a level-1/pos-5 switch and a root switch side by side against
// an arithmetic model of the routing, ageing and counting rules.
module tb_t_route_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [48:0] l_bus, r_bus, u_bus;
    logic        cnt_clr;
    logic [1:0]  cnt_sel;
    logic [48:0] pk [2][3];
    logic [1:0]  dd [2][3];
    logic [15:0] co [2];
    int          total = 0;
    int          bad = 0;
    int          mc [2][4];
    logic [48:0] ep [2][3];
    logic [1:0]  ed [2][3];

    always #5 clk = ~clk;

    t_route_stage #(.level(1), .pos(5)) dut (
        .clk(clk), .reset(reset),
        .l_bus_i(l_bus), .r_bus_i(r_bus), .u_bus_i(u_bus),
        .l_pkt_o(pk[0][0]), .r_pkt_o(pk[0][1]), .u_pkt_o(pk[0][2]),
        .d_l(dd[0][0]), .d_r(dd[0][1]), .d_u(dd[0][2]),
        .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_o(co[0])
    );

    t_route_stage #(.level(2), .pos(0)) rt (
        .clk(clk), .reset(reset),
        .l_bus_i(l_bus), .r_bus_i(r_bus), .u_bus_i(u_bus),
        .l_pkt_o(pk[1][0]), .r_pkt_o(pk[1][1]), .u_pkt_o(pk[1][2]),
        .d_l(dd[1][0]), .d_r(dd[1][1]), .d_u(dd[1][2]),
        .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_o(co[1])
    );

    function automatic logic [48:0] mk(input logic v, input logic [7:0] a, input logic [3:0] g,
                                       input logic [35:0] rest);
        return {v, a, g, rest};
    endfunction

    function automatic logic [48:0] rnd();
        logic [7:0] a;
        a = $urandom_range(1) ? {6'd5, 2'($urandom)} : 8'($urandom);
        return mk($urandom_range(3) != 0, a, 4'($urandom), 36'({$urandom, $urandom}));
    endfunction

    // k=0: level 1, pos 5; k=1: root at level 2
    function automatic logic [1:0] rdir(input logic [48:0] p, input int k);
        int lv, ps, a;
        lv = k ? 2 : 1;
        ps = k ? 0 : 5;
        a = int'(p[47:40]);
        if (!p[48]) return 2'b00;
        if (lv != 2 && a / (1 << (lv + 1)) != ps % (1 << (7 - lv))) return 2'b11;
        return ((a >> lv) % 2) != 0 ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [48:0] rpkt(input logic [48:0] p);
        logic [48:0] q;
        int g;
        if (!p[48]) return '0;
        g = int'(p[39:36]);
        q = p;
        q[39:36] = 4'(g == 15 ? 15 : g + 1);
        return q;
    endfunction

    function automatic int sat(input int v);
        return v > 65535 ? 65535 : v;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("%s_pkt%0d%0d", tag, k, j), 64'(pk[k][j]), 64'(ep[k][j]));
                chk($sformatf("%s_dir%0d%0d", tag, k, j), 64'(dd[k][j]), 64'(ed[k][j]));
            end
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            for (int k = 0; k < 2; k++)
                chk($sformatf("%s_cnt%0d_sel%0d", tag, k, s), 64'(co[k]), 64'(mc[k][s]));
        end
    endtask

    task automatic model_in(input logic [48:0] l, input logic [48:0] r, input logic [48:0] u,
                            input logic clr);
        logic [48:0] in [3];
        int nup;
        in = '{l, r, u};
        l_bus = l;
        r_bus = r;
        u_bus = u;
        cnt_clr = clr;
        for (int k = 0; k < 2; k++) begin
            nup = 0;
            for (int j = 0; j < 3; j++) begin
                ed[k][j] = rdir(in[j], k);
                ep[k][j] = rpkt(in[j]);
                if (ed[k][j] == 2'b11) nup++;
                mc[k][j] = clr ? 0 : sat(mc[k][j] + int'(in[j][48]));
            end
            mc[k][3] = clr ? 0 : sat(mc[k][3] + nup);
        end
    endtask

    task automatic step(input logic [48:0] l, input logic [48:0] r, input logic [48:0] u,
                        input logic clr);
        model_in(l, r, u, clr);
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    task automatic zero_model();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                ep[k][j] = '0;
                ed[k][j] = 2'b00;
            end
            for (int s = 0; s < 4; s++) mc[k][s] = 0;
        end
    endtask

    initial begin
        logic [48:0] p30, p14;
        reset = 1'b1;
        l_bus = '0;
        r_bus = '0;
        u_bus = '0;
        cnt_clr = 1'b0;
        cnt_sel = 2'd0;
        zero_model();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        step(mk(1'b1, 8'h14, 4'd0, 36'h123), '0, '0, 1'b0);
        chk("lit_left", 64'(dd[0][0]), 64'(2'b01));
        step(mk(1'b1, 8'h16, 4'd0, 36'h456), '0, '0, 1'b0);
        chk("lit_right", 64'(dd[0][0]), 64'(2'b10));
        step(mk(1'b1, 8'h30, 4'd0, 36'h789), '0, '0, 1'b0);
        chk("lit_up", 64'(dd[0][0]), 64'(2'b11));

        step('0, mk(1'b1, 8'hFF, 4'd15, 36'hABC), '0, 1'b0);
        chk("root_right", 64'(dd[1][1]), 64'(2'b10));
        chk("root_age_sat", 64'(pk[1][1][39:36]), 64'd15);
        step('0, mk(1'b1, 8'hFF, 4'd3, 36'hDEF), '0, 1'b0);
        chk("root_age_inc", 64'(pk[1][1][39:36]), 64'd4);

        p30 = mk(1'b1, 8'h30, 4'd2, 36'h55);
        step('0, '0, '0, 1'b1);
        step(p30, p30, p30, 1'b0);
        cnt_sel = 2'd3;
        #1;
        chk("up3", 64'(co[0]), 64'd3);
        step('0, '0, '0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("void_dir%0d", j), 64'(dd[0][j]), 64'd0);
            chk($sformatf("void_pkt%0d", j), 64'(pk[0][j]), 64'd0);
        end
        cnt_sel = 2'd3;
        #1;
        chk("up3_hold", 64'(co[0]), 64'd3);

        repeat (400) step(rnd(), rnd(), rnd(), $urandom_range(31) == 0);

        p14 = mk(1'b1, 8'h14, 4'd7, 36'h99);
        step(p14, mk(1'b1, 8'h16, 4'd1, 36'h1), mk(1'b1, 8'h30, 4'd1, 36'h2), 1'b0);
        #2;
        reset = 1'b1;
        zero_model();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(p14, '0, '0, 1'b0);
        chk("post_rst_left", 64'(dd[0][0]), 64'(2'b01));

        step('0, '0, '0, 1'b1);
        model_in(p14, '0, '0, 1'b0);
        mc[0][0] = 65534;
        mc[1][0] = 65534;
        repeat (65534) @(posedge clk);
        #1;
        check_all("preload");
        cnt_sel = 2'd0;
        #1;
        chk("preload_lit", 64'(co[0]), 64'hFFFE);
        repeat (3) step(p14, '0, '0, 1'b0);
        cnt_sel = 2'd0;
        #1;
        chk("sat_lit", 64'(co[0]), 64'hFFFF);
        step(p14, '0, '0, 1'b1);
        cnt_sel = 2'd0;
        #1;
        chk("clr_lit", 64'(co[0]), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/t_route_stage.md
T_ROUTE_STAGE -- requirements
Module: t_route_stage

Interface
REQ-001 The block SHALL provide parameters, one per line: name, default, meaning.
 P_W  49  packet width; bit P_W-1 is valid.
 A_W  8  destination address width, bits [P_W-2:P_W-1-A_W].
 AGE_W  4  age field width, bits directly below address.
 level  1  tree level of this switch (0 = leaf-adjacent).
 pos  0  switch index within its level.
 N_LEVELS  3  total levels; level N_LEVELS-1 is the root (no up link).
REQ-002 The block SHALL provide ports, one per line: name  direction  width  meaning.
 clk  in  1  single clock, rising edge.
 reset  in  1  asynchronous, active-high reset.
 l_bus_i / r_bus_i / u_bus_i  in  P_W  packets arriving from left child, right child, parent.
 l_pkt_o / r_pkt_o / u_pkt_o  out  P_W  registered packets presented to the output muxes.
 d_l / d_r / d_u  out  2  registered desired direction, feeds the t_arbiter; 00 VOID, 01 LEFT, 10 RIGHT, 11 UP.
 cnt_clr  in  1  synchronous clear of all statistics counters.
 cnt_sel  in  2  counter select: 00 left, 01 right, 10 up-port arrivals, 11 UP requests.
 cnt_o  out  16  selected counter value, combinational from registers.

Function
REQ-003 The block SHALL register all three ports every cycle; latency input -> pkt_o/d_x is exactly 1 cycle; no stall or backpressure exists (deflection network).
REQ-004 An input with valid=0 SHALL load all-zero into its pkt_o register and VOID into its d_x.
REQ-005 For a valid input, subtree match SHALL be addr[A_W-1:level+1] == pos (truncated to A_W-level-1 bits); at level == N_LEVELS-1 match SHALL be forced true.
REQ-006 Valid and matching: d_x SHALL be LEFT if addr[level]=0, RIGHT if addr[level]=1; valid and not matching: d_x SHALL be UP.
REQ-007 Decode SHALL apply identically on all three ports; a left-port packet decoding LEFT (turnback) or up-port packet decoding UP is passed unchanged to the arbiter.
REQ-008 The registered packet SHALL equal the input with age field incremented by 1, saturating at 2^AGE_W-1; all other bits unchanged.
REQ-009 Per-port 16-bit arrival counters SHALL increment on each valid input; the UP-request counter SHALL increment by the number (0..3) of valid inputs decoding UP in that cycle.
REQ-010 All counters SHALL saturate at 0xFFFF; never wrap.
REQ-011 cnt_clr SHALL zero all counters on the next edge; clear SHALL win over a simultaneous increment.
REQ-012 cnt_sel changes SHALL reflect on cnt_o in the same cycle.

Reset
REQ-013 While reset=1, all pkt_o SHALL be 0, all d_x SHALL be VOID, all counters SHALL be 0, asynchronously and independent of clk.
REQ-014 Reset asserted mid-traffic SHALL discard any registered packet; first post-release edge samples inputs normally.

Verification
REQ-015 A_W=8, level=1, pos=5, N_LEVELS=3: valid l_bus_i addr 0x14 -> next cycle d_l=LEFT; addr 0x16 -> d_l=RIGHT; addr 0x30 -> d_l=UP.
REQ-016 Root config (level=2, N_LEVELS=3, pos=0), u_bus_i invalid, r_bus_i addr 0xFF -> d_r=RIGHT, never UP; input age 15 -> r_pkt_o age stays 15; age 3 -> 4.
REQ-017 Same cycle all three ports valid, all decode UP -> UP-request counter +3; cnt_sel=11 shows 3; invalid inputs -> d_x=VOID, pkt_o=0, counters unchanged.
REQ-018 Preload left counter to 0xFFFE, send 3 valid packets -> cnt_o (sel 00) = 0xFFFF; assert cnt_clr together with a valid packet -> 0x0000.
REQ-019 Assert reset between clock edges while pkt_o holds data -> pkt_o=0, d_x=VOID immediately; release and drive addr 0x14 on left -> d_l=LEFT one cycle later.
